// File: rtl/nios_setup_v2_button_in.sv
// Avalon-MM input PIO: synchronises and debounces button pins, latches selected edges
// into sticky capture bits and raises a level IRQ for unmasked captures.
module nios_setup_v2_button_in #(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 1000,
  parameter int unsigned      EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned     CntW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] rise, fall, evt;
  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [CntW-1:0]  cnt_d [WIDTH];
  logic             wr_en;

  assign wr_en = chipselect & ~write_n;

  // Two-flop synchroniser for the raw asynchronous pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RESET_VALUE;
      sync2_q <= RESET_VALUE;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: a changed level must persist DEBOUNCE_CYCLES cycles to be accepted.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // Debounce state; prev tracks stable one cycle behind for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= RESET_VALUE;
      prev_q   <= RESET_VALUE;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      prev_q   <= stable_q;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Edge selection.
  always_comb begin
    rise = stable_q & ~prev_q;
    fall = ~stable_q & prev_q;
    if (EDGE_TYPE == 0) begin
      evt = rise;
    end else if (EDGE_TYPE == 1) begin
      evt = fall;
    end else begin
      evt = rise | fall;
    end
  end

  // Software-visible registers; a new event outranks a same-cycle clear.
  always_comb begin
    mask_d = mask_q;
    cap_d  = cap_q;
    if (wr_en && address == 2'd2) mask_d = writedata[WIDTH-1:0];
    if (wr_en && address == 2'd3) cap_d = cap_q & ~writedata[WIDTH-1:0];
    cap_d = cap_d | evt;
  end

  // Mask and capture registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      cap_q  <= '0;
    end else begin
      mask_q <= mask_d;
      cap_q  <= cap_d;
    end
  end

  // Zero-latency read mux, zero-extended.
  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0: readdata = 32'(stable_q);
      2'd1: readdata = '0;
      2'd2: readdata = 32'(mask_q);
      2'd3: readdata = 32'(cap_q);
      default: readdata = '0;
    endcase
  end

  assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_nios_setup_v2_button_in.sv
// Self-checking bench: directed scenarios plus randomised pins and bus traffic, checked every
// cycle against a window-based behavioural model of the debounced PIO.
module tb_nios_setup_v2_button_in;

  localparam int unsigned W  = 4;
  localparam int unsigned D  = 4;
  localparam logic [3:0]  RV = 4'hF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_port = RV;
  logic [31:0] readdata;
  logic        irq;

  always #5 clk = ~clk;

  nios_setup_v2_button_in #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .EDGE_TYPE      (1),
    .RESET_VALUE    (RV)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: stable level, mask, captures, falling events awaiting capture.
  logic [3:0] m_stable, m_mask, m_cap, m_pend;
  logic [3:0] m_dly[$];  // two-cycle pin delay
  logic [3:0] m_win[$];  // last D delayed samples since reset
  logic [31:0] rd_seen;
  logic        irq_seen;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'b0, m_stable};
      2'd2:    return {28'b0, m_mask};
      2'd3:    return {28'b0, m_cap};
      default: return 32'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_stable = RV;
    m_mask   = '0;
    m_cap    = '0;
    m_pend   = '0;
    m_dly.delete();
    m_dly.push_back(RV);
    m_dly.push_back(RV);
    m_win.delete();
  endtask

  // A level flips once the last D delayed samples all disagree with it.
  task automatic model_step(input logic [3:0] pin, input logic wr, input logic [1:0] a,
                            input logic [31:0] wd);
    logic [3:0] s, ns, clr, capn;
    clr  = (wr && a == 2'd3) ? wd[3:0] : 4'h0;
    capn = (m_cap & ~clr) | m_pend;
    if (wr && a == 2'd2) m_mask = wd[3:0];
    s = m_dly.pop_front();
    m_dly.push_back(pin);
    m_win.push_back(s);
    if (m_win.size() > D) void'(m_win.pop_front());
    ns = m_stable;
    if (m_win.size() == D) begin
      for (int b = 0; b < 4; b++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int k = 0; k < m_win.size(); k++) begin
          if (m_win[k][b] == m_stable[b]) all_diff = 1'b0;
        end
        if (all_diff) ns[b] = ~m_stable[b];
      end
    end
    m_pend   = m_stable & ~ns;
    m_stable = ns;
    m_cap    = capn;
  endtask

  // One bus cycle: drive at negedge, check before the edge, then advance the model.
  task automatic cycle(input logic [3:0] pin, input logic cs, input logic wn,
                       input logic [1:0] a, input logic [31:0] wd);
    @(negedge clk);
    in_port    = pin;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    #1;
    rd_seen  = readdata;
    irq_seen = irq;
    check_val($sformatf("read_a%0d", a), readdata, model_read(a));
    check_val("irq", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
    @(posedge clk);
    model_step(pin, cs && !wn, a, wd);
  endtask

  task automatic rd(input logic [3:0] pin, input logic [1:0] a);
    cycle(pin, 1'b1, 1'b1, a, 32'h0);
  endtask

  task automatic wr(input logic [3:0] pin, input logic [1:0] a, input logic [31:0] wd);
    cycle(pin, 1'b1, 1'b0, a, wd);
  endtask

  task automatic do_reset(input logic [3:0] pin);
    @(negedge clk);
    in_port    = pin;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd3;
    #2 reset_n = 1'b0;
    #1;
    check_val("rst_irq", {31'b0, irq}, 32'h0);
    check_val("rst_cap", readdata, 32'h0);
    address = 2'd0;
    #1;
    check_val("rst_data", readdata, {28'b0, RV});
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    model_step(pin, 1'b0, 2'd0, 32'h0);
  endtask

  initial begin
    logic [3:0] cur;
    model_reset();
    do_reset(RV);

    // Reset values.
    rd(RV, 2'd0); check_val("init_data", rd_seen, 32'hF);
    rd(RV, 2'd1); check_val("init_rsvd", rd_seen, 32'h0);
    rd(RV, 2'd2); check_val("init_mask", rd_seen, 32'h0);
    rd(RV, 2'd3); check_val("init_cap", rd_seen, 32'h0);

    // Falling edge on bit0: accepted after exactly 6 edges, captured one edge later.
    for (int j = 1; j <= 7; j++) begin
      rd(4'hE, 2'd0);
      if (j == 6) check_val("data_before_6", rd_seen, 32'hF);
      if (j == 7) check_val("data_at_6", rd_seen, 32'hE);
    end
    rd(4'hE, 2'd3);
    check_val("cap_bit0", rd_seen, 32'h1);
    check_val("irq_masked", {31'b0, irq_seen}, 32'h0);

    // Short glitch on bit1 is rejected.
    wr(4'hE, 2'd3, 32'hF);
    repeat (3) rd(4'hC, 2'd0);
    repeat (10) rd(4'hE, 2'd0);
    check_val("glitch_data", rd_seen, 32'hE);
    rd(4'hE, 2'd3);
    check_val("glitch_cap", rd_seen, 32'h0);

    // Four-cycle hold is accepted; the following rise is not captured.
    repeat (4) rd(4'hC, 2'd0);
    repeat (12) rd(4'hE, 2'd0);
    rd(4'hE, 2'd3);
    check_val("hold4_cap", rd_seen, 32'h2);

    // Unmasked capture raises irq; a clear drops it on the next cycle.
    wr(4'hE, 2'd3, 32'hF);
    wr(4'hE, 2'd2, 32'h2);
    repeat (8) rd(4'hC, 2'd3);
    check_val("irq_on", {31'b0, irq_seen}, 32'h1);
    wr(4'hC, 2'd3, 32'h2);
    rd(4'hC, 2'd3);
    check_val("irq_cleared", {31'b0, irq_seen}, 32'h0);
    repeat (10) rd(4'hE, 2'd3);
    check_val("no_rise_cap", rd_seen, 32'h0);

    // Clear landing in the same cycle as a new event: the set wins.
    repeat (6) rd(4'hA, 2'd3);
    wr(4'hA, 2'd3, 32'hF);
    rd(4'hA, 2'd3);
    check_val("set_wins", rd_seen, 32'h4);
    check_val("irq_mask_off", {31'b0, irq_seen}, 32'h0);
    wr(4'hA, 2'd2, 32'h4);
    rd(4'hA, 2'd3);
    check_val("irq_follows_mask", {31'b0, irq_seen}, 32'h1);

    // Reset during active irq and a debounce in progress.
    repeat (10) rd(RV, 2'd0);
    wr(RV, 2'd3, 32'hF);
    wr(RV, 2'd2, 32'h3);
    repeat (8) rd(4'hC, 2'd3);
    check_val("pre_rst_cap", rd_seen, 32'h3);
    check_val("pre_rst_irq", {31'b0, irq_seen}, 32'h1);
    repeat (2) rd(4'h4, 2'd0);
    do_reset(4'h4);
    repeat (10) rd(4'h4, 2'd3);
    check_val("post_rst_edge", rd_seen, 32'hB);

    // Randomised pins and bus traffic.
    cur = 4'h4;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
      end
      if ($urandom_range(0, 499) == 0) begin
        do_reset(cur);
      end else begin
        cycle(cur, $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
              2'($urandom_range(0, 3)), $urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
